// File: rtl/scan_chain_ctrl_pkg.sv
// Shared types and constants for the scan chain controller and its optional
// signature register.
package scan_chain_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WAIT    = 3'd3,
        ST_UNLOAD  = 3'd4
    } state_e;

    localparam int              MISR_W    = 16;
    localparam logic [MISR_W-1:0] MISR_POLY = 16'h8016;

    // One MISR step: shift left, fold the feedback polynomial on carry-out, absorb data.
    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] sig,
                                                    input logic [MISR_W-1:0] data);
        return {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : '0) ^ data;
    endfunction

endpackage

// File: rtl/scan_chain_ctrl_misr.sv
// Response signature register: XOR-folds each committed response to 16 bits
// and compacts it into a MISR. Only instantiated when SCAN_CHAIN_CTRL_MISR_EN is defined.
module scan_chain_ctrl_misr
    import scan_chain_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] fold;

    always_comb begin
        fold = '0;
        for (int i = 0; i < DATA_W; i++) begin
            fold[i % MISR_W] = fold[i % MISR_W] ^ data[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= misr_step(sig, fold);
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shifts patterns in, pulses one capture, unloads responses
// overlapped with the next pattern. Optional MISR via SCAN_CHAIN_CTRL_MISR_EN.
module scan_chain_ctrl
    import scan_chain_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic [CHAIN_LEN-1:0] PAT,
    input  logic                 PAT_LAST,
    input  logic                 PAT_VALID,
    output logic                 PAT_READY,
    output logic [CHAIN_LEN-1:0] RESP,
    output logic                 RESP_VALID,
    input  logic                 RESP_READY,
    output logic                 SE,
    output logic                 SI,
    input  logic                 SO,
    output logic                 CKE,
    output logic                 BUSY,
`ifdef SCAN_CHAIN_CTRL_MISR_EN
    input  logic                 SIG_CLR,
    output logic [MISR_W-1:0]    SIG,
`endif
    output state_e               dbg_state
);

    localparam int             CW       = $clog2(CHAIN_LEN);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CHAIN_LEN - 1);

    // Handshakes: a transfer happens on the CK edge where VALID && READY; VALID
    // never waits on READY, and RESP/RESP_VALID stay stable until that edge.
    state_e               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [CHAIN_LEN-1:0] sin, sin_n, sout, sout_n, so_shift, resp_n;
    logic                 last, last_n, pend, pend_n, hold, hold_n;
    logic                 accept, buf_free, at_end, commit, resp_valid_n;
    logic                 pat_ready_n, se_n, si_n, cke_n, busy_n;

    assign dbg_state = state;

    always_comb begin
        accept   = PAT_VALID && PAT_READY;
        buf_free = !RESP_VALID || RESP_READY;
        at_end   = (cnt == CNT_LAST);
        so_shift = {SO, sout[CHAIN_LEN-1:1]};
        state_n  = state;
        cnt_n    = cnt;
        sin_n    = sin;
        sout_n   = sout;
        last_n   = last;
        pend_n   = pend;
        hold_n   = hold;
        commit   = 1'b0;
        resp_n   = RESP;

        case (state)
            ST_IDLE, ST_WAIT: begin
                if (accept) begin
                    sin_n   = PAT;
                    last_n  = PAT_LAST;
                    cnt_n   = '0;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT, ST_UNLOAD: begin
                if (hold) begin
                    // The chain already took its final shift; only the commit is outstanding.
                    if (buf_free) begin
                        commit  = 1'b1;
                        resp_n  = sout;
                        pend_n  = 1'b0;
                        hold_n  = 1'b0;
                        cnt_n   = '0;
                        state_n = (state == ST_SHIFT) ? ST_CAPTURE : ST_IDLE;
                    end
                end else begin
                    sin_n  = sin >> 1;
                    sout_n = so_shift;
                    if (!at_end) begin
                        cnt_n = cnt + CW'(1);
                    end else if (pend && !buf_free) begin
                        hold_n = 1'b1;
                    end else begin
                        if (pend) begin
                            commit = 1'b1;
                            resp_n = so_shift;
                            pend_n = 1'b0;
                        end
                        cnt_n   = '0;
                        state_n = (state == ST_SHIFT) ? ST_CAPTURE : ST_IDLE;
                    end
                end
            end
            ST_CAPTURE: begin
                pend_n = 1'b1;
                cnt_n  = '0;
                if (accept) begin
                    sin_n   = PAT;
                    last_n  = PAT_LAST;
                    state_n = ST_SHIFT;
                end else if (last) begin
                    state_n = ST_UNLOAD;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        resp_valid_n = commit ? 1'b1 : (RESP_READY ? 1'b0 : RESP_VALID);

        // Outputs are registered, so they are decoded from the state being entered.
        pat_ready_n = 1'b0;
        se_n        = 1'b0;
        si_n        = 1'b0;
        cke_n       = 1'b0;
        busy_n      = (state_n != ST_IDLE);
        case (state_n)
            ST_IDLE:    pat_ready_n = 1'b1;
            ST_SHIFT: begin
                se_n  = 1'b1;
                cke_n = !hold_n;
                si_n  = sin_n[0];
            end
            ST_CAPTURE: begin
                cke_n       = 1'b1;
                pat_ready_n = !last_n;
            end
            ST_WAIT: begin
                se_n        = 1'b1;
                pat_ready_n = 1'b1;
            end
            ST_UNLOAD: begin
                se_n  = 1'b1;
                cke_n = !hold_n;
            end
            default: pat_ready_n = 1'b0;
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sin        <= '0;
            sout       <= '0;
            last       <= 1'b0;
            pend       <= 1'b0;
            hold       <= 1'b0;
            PAT_READY  <= 1'b0;
            RESP       <= '0;
            RESP_VALID <= 1'b0;
            SE         <= 1'b0;
            SI         <= 1'b0;
            CKE        <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sin        <= sin_n;
            sout       <= sout_n;
            last       <= last_n;
            pend       <= pend_n;
            hold       <= hold_n;
            PAT_READY  <= pat_ready_n;
            RESP       <= resp_n;
            RESP_VALID <= resp_valid_n;
            SE         <= se_n;
            SI         <= si_n;
            CKE        <= cke_n;
            BUSY       <= busy_n;
        end
    end

`ifdef SCAN_CHAIN_CTRL_MISR_EN
    scan_chain_ctrl_misr #(
        .DATA_W (CHAIN_LEN)
    ) u_misr (
        .clk   (CK),
        .rst_n (RN),
        .clr   (SIG_CLR),
        .en    (commit),
        .data  (resp_n),
        .sig   (SIG)
    );
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with a behavioural DFF+mux chain whose functional D is
// the inverse of its own Q, so every response must equal the inverted pattern.
module tb_scan_chain_ctrl;

    localparam int N = 8;

    logic         ck = 1'b0;
    logic         rn = 1'b0;
    logic [N-1:0] pat = '0;
    logic         pat_last = 1'b0;
    logic         pat_valid = 1'b0;
    logic         pat_ready;
    logic [N-1:0] resp;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic         se, si, cke, busy;
    logic         so;
    logic [2:0]   dbg_state;
`ifdef SCAN_CHAIN_CTRL_MISR_EN
    logic         sig_clr = 1'b0;
    logic [15:0]  sig;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Scoreboard state, written only by the compare process.
    logic [N-1:0] exp_q[$];
    logic [N-1:0] got_q[$];
    int           acc_q[$];
    int           rise_q[$];
    int           frozen_cycles = 0;
    int           se_low_cycles = 0;
    logic         prev_hold = 1'b0;
    logic         prev_rv = 1'b0;
    logic         prev_cap = 1'b0;
    logic [N-1:0] prev_resp = '0;
    logic [N-1:0] exp_v;

    scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
        .CK         (ck),
        .RN         (rn),
        .PAT        (pat),
        .PAT_LAST   (pat_last),
        .PAT_VALID  (pat_valid),
        .PAT_READY  (pat_ready),
        .RESP       (resp),
        .RESP_VALID (resp_valid),
        .RESP_READY (resp_ready),
        .SE         (se),
        .SI         (si),
        .SO         (so),
        .CKE        (cke),
        .BUSY       (busy),
`ifdef SCAN_CHAIN_CTRL_MISR_EN
        .SIG_CLR    (sig_clr),
        .SIG        (sig),
`endif
        .dbg_state  (dbg_state)
    );

    // Clock and cycle count
    always #5 ck = ~ck;
    always @(posedge ck) cyc <= cyc + 1;

    // Behavioural scan chain
    logic [N-1:0] chain_q = '0;
    always @(posedge ck) begin
        if (cke) begin
            if (se) chain_q <= {chain_q[N-2:0], si};
            else    chain_q <= ~chain_q;
        end
    end
    assign so = chain_q[N-1];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [N-1:0] r);
        logic [15:0] nxt;
        nxt = s << 1;
        if (s[15]) nxt = nxt ^ 16'h8016;
        return nxt ^ {8'h00, r};
    endfunction

    // Compare process: every response is the inverse of the pattern accepted in order
    always @(negedge ck) begin
        if (!rn) begin
            exp_q.delete();
            prev_hold = 1'b0;
            prev_rv   = 1'b0;
            prev_cap  = 1'b0;
        end else begin
            if (pat_valid && pat_ready) begin
                exp_q.push_back(~pat);
                acc_q.push_back(cyc + 1);
            end
            if (resp_valid && !prev_rv) rise_q.push_back(cyc);
            if (prev_hold) begin
                check("resp_held_valid", resp_valid, 1);
                check("resp_held_data", resp, prev_resp);
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL resp_unexpected: got 0x%0h, want no response", resp);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("resp_data", resp, exp_v);
                end
                got_q.push_back(resp);
            end
            if (busy && !se) begin
                check("capture_cke", cke, 1);
                check("se_low_single", prev_cap, 0);
                se_low_cycles++;
            end
            if (!busy) check("idle_quiet", {se, cke}, 0);
            if (busy && !cke) frozen_cycles++;
            prev_hold = resp_valid && !resp_ready;
            prev_rv   = resp_valid;
            prev_cap  = busy && !se;
            prev_resp = resp;
        end
    end

    // Driver tasks; callers sit just after a rising edge
    task automatic offer(input logic [N-1:0] p, input logic l);
        int n;
        n = 0;
        pat       = p;
        pat_last  = l;
        pat_valid = 1'b1;
        do begin
            @(negedge ck);
            n++;
        end while (!pat_ready && n < 200);
        check("offer_accepted", pat_ready, 1);
        @(posedge ck);
        #1;
        pat_valid = 1'b0;
        pat_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge ck);
            n++;
        end while ((busy || resp_valid) && n < 300);
        check(name, busy || resp_valid, 0);
        @(posedge ck);
        #1;
    endtask

    int s_got, s_acc, s_rise, s_fz, s_se, n_w;
    logic [15:0] m_sig;

    initial begin
        // Reset state
        #12;
        check("rst_outputs", {pat_ready, resp_valid, resp, se, si, cke, busy}, 0);
        @(posedge ck);
        #1;
        rn = 1'b1;
        @(negedge ck);
        @(negedge ck);
        check("rel_busy", busy, 0);
        check("rel_pat_ready", pat_ready, 1);
        @(posedge ck);
        #1;

        // Single pattern
        s_got = got_q.size(); s_acc = acc_q.size(); s_rise = rise_q.size();
        s_fz = frozen_cycles; s_se = se_low_cycles;
        offer(8'hA5, 1'b1);
        wait_idle("single_done");
        check("single_count", got_q.size() - s_got, 1);
        if (got_q.size() > s_got) check("single_resp", got_q[s_got], 8'h5A);
        if (rise_q.size() > s_rise && acc_q.size() > s_acc)
            check("single_latency", rise_q[s_rise] - acc_q[s_acc], 17);
        check("single_se_low", se_low_cycles - s_se, 1);
        check("single_frozen", frozen_cycles - s_fz, 0);

        // Back-to-back burst
        s_got = got_q.size(); s_acc = acc_q.size();
        s_fz = frozen_cycles; s_se = se_low_cycles;
        offer(8'h01, 1'b0);
        offer(8'h80, 1'b0);
        offer(8'hFF, 1'b1);
        wait_idle("b2b_done");
        check("b2b_count", got_q.size() - s_got, 3);
        if (got_q.size() >= s_got + 3) begin
            check("b2b_resp0", got_q[s_got], 8'hFE);
            check("b2b_resp1", got_q[s_got + 1], 8'h7F);
            check("b2b_resp2", got_q[s_got + 2], 8'h00);
        end
        if (acc_q.size() >= s_acc + 3) begin
            check("b2b_gap0", acc_q[s_acc + 1] - acc_q[s_acc], 9);
            check("b2b_gap1", acc_q[s_acc + 2] - acc_q[s_acc + 1], 9);
        end
        check("b2b_no_wait", frozen_cycles - s_fz, 0);
        check("b2b_se_low", se_low_cycles - s_se, 3);

        // Backpressure: hold the response buffer full across a commit
        s_got = got_q.size(); s_fz = frozen_cycles;
        resp_ready = 1'b0;
        offer(8'h12, 1'b0);
        offer(8'h34, 1'b0);
        offer(8'h56, 1'b1);
        n_w = 0;
        do begin
            @(negedge ck);
            n_w++;
        end while (!(busy && !cke) && n_w < 100);
        check("bp_stall_seen", busy && !cke, 1);
        check("bp_resp_valid", resp_valid, 1);
        check("bp_resp_held", resp, 8'hED);
        repeat (4) @(posedge ck);
        #1;
        resp_ready = 1'b1;
        wait_idle("bp_done");
        check("bp_stall_cycles", frozen_cycles - s_fz, 5);
        check("bp_count", got_q.size() - s_got, 3);
        if (got_q.size() >= s_got + 3) begin
            check("bp_resp0", got_q[s_got], 8'hED);
            check("bp_resp1", got_q[s_got + 1], 8'hCB);
            check("bp_resp2", got_q[s_got + 2], 8'hA9);
        end

        // Reset in the middle of a shift
        offer(8'h77, 1'b1);
        repeat (3) @(posedge ck);
        #1;
        rn = 1'b0;
        #1;
        check("mid_rst_outputs", {pat_ready, resp_valid, resp, se, si, cke, busy}, 0);
        @(posedge ck);
        @(posedge ck);
        #1;
        rn = 1'b1;
        @(negedge ck);
        @(negedge ck);
        check("mid_rel_busy", busy, 0);
        check("mid_rel_pat_ready", pat_ready, 1);
        check("mid_rel_resp_valid", resp_valid, 0);
        @(posedge ck);
        #1;
        s_got = got_q.size();
        offer(8'h3C, 1'b1);
        wait_idle("mid_after_done");
        check("mid_after_count", got_q.size() - s_got, 1);
        if (got_q.size() > s_got) check("mid_after_resp", got_q[s_got], 8'hC3);

`ifdef SCAN_CHAIN_CTRL_MISR_EN
        // Signature over two responses
        sig_clr = 1'b1;
        @(posedge ck);
        #1;
        sig_clr = 1'b0;
        @(negedge ck);
        check("sig_clr_start", sig, 0);
        @(posedge ck);
        #1;
        offer(8'hA5, 1'b0);
        offer(8'h3C, 1'b1);
        wait_idle("sig_done");
        m_sig = misr_ref(misr_ref(16'h0000, 8'h5A), 8'hC3);
        check("sig_model", sig, m_sig);
        check("sig_literal", sig, 16'h0077);
        sig_clr = 1'b1;
        @(posedge ck);
        #1;
        sig_clr = 1'b0;
        @(negedge ck);
        check("sig_clr_end", sig, 0);
`endif

        repeat (3) @(posedge ck);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
